// File: rtl/seq_array_mult.sv
// Sequential shift-and-add multiplier, one partial-product row per clock.
// Start/busy/done handshake with optional two's-complement operands.
module seq_array_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [PW-1:0]    acc;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    count;
  logic             neg;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [PW-1:0]    acc_sum;
  logic [PW-1:0]    result;
  logic             last;
  logic             accept;

  // Operand magnitudes; -2^(W-1) negates to itself, read as unsigned.
  always_comb begin
    mag_a = a;
    mag_b = b;
    if (signed_mode && a[WIDTH-1]) mag_a = -a;
    if (signed_mode && b[WIDTH-1]) mag_b = -b;
  end

  // Next accumulator value and the sign-corrected final product.
  always_comb begin
    acc_sum = acc + (mplier[0] ? mcand : '0);
    result  = neg ? -acc_sum : acc_sum;
    last    = (count == CW'(WIDTH - 1));
    accept  = start && (state == IDLE || state == DONE);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch on accept, then one multiplier bit per RUN cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
      neg    <= 1'b0;
      p      <= '0;
    end else if (accept) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, mag_a};
      mplier <= mag_b;
      count  <= '0;
      neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (state == RUN) begin
      acc    <= acc_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + CW'(1);
      if (last) p <= result;
    end
  end

endmodule

// File: tb/tb_seq_array_mult.sv
// Scoreboard bench for seq_array_mult at WIDTH=8 and WIDTH=4.
// Expected products and done cycles are queued at start time.
module tb_seq_array_mult;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] p;
    int          at;
  } exp_t;

  exp_t q8[$];
  exp_t q4[$];

  logic       start8 = 1'b0;
  logic       s8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       busy8;
  logic       done8;
  logic [15:0] p8;

  logic       start4 = 1'b0;
  logic       s4 = 1'b0;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic       busy4;
  logic       done4;
  logic [7:0] p4;

  seq_array_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8),
    .signed_mode(s8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .p(p8)
  );

  seq_array_mult #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4),
    .signed_mode(s4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .p(p4)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] x,
                                          input logic [31:0] y,
                                          input logic s,
                                          input int w);
    longint xi;
    longint yi;
    longint pr;
    xi = longint'(x);
    yi = longint'(y);
    if (s && x[w-1]) xi = xi - (longint'(1) << w);
    if (s && y[w-1]) yi = yi - (longint'(1) << w);
    pr = xi * yi;
    return 64'(pr) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  // Scoreboard monitors: compare product and arrival cycle on done.
  always @(negedge clk) begin
    exp_t e;
    if (done8) begin
      check("excl8", {63'd0, busy8}, 64'd0);
      if (q8.size() == 0) begin
        check("spurious8", 64'd1, 64'd0);
      end else begin
        e = q8.pop_front();
        check("p8", {48'd0, p8}, e.p);
        check("lat8", 64'(cyc), 64'(e.at));
      end
    end
    if (done4) begin
      if (q4.size() == 0) begin
        check("spurious4", 64'd1, 64'd0);
      end else begin
        e = q4.pop_front();
        check("p4", {56'd0, p4}, e.p);
        check("lat4", 64'(cyc), 64'(e.at));
      end
    end
  end

  task automatic drive8(input logic [7:0] x, input logic [7:0] y,
                        input logic s);
    @(negedge clk);
    a8 = x; b8 = y; s8 = s; start8 = 1'b1;
    q8.push_back('{ref_mul(32'(x), 32'(y), s, 8), cyc + 1 + 8});
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic drive4(input logic [3:0] x, input logic [3:0] y,
                        input logic s);
    @(negedge clk);
    a4 = x; b4 = y; s4 = s; start4 = 1'b1;
    q4.push_back('{ref_mul(32'(x), 32'(y), s, 4), cyc + 1 + 4});
    @(negedge clk);
    start4 = 1'b0;
  endtask

  task automatic drain8();
    int n = 0;
    while (q8.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (q8.size() != 0) begin
      check("timeout8", 64'(q8.size()), 64'd0);
      q8.delete();
    end
  endtask

  task automatic drain4();
    int n = 0;
    while (q4.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (q4.size() != 0) begin
      check("timeout4", 64'(q4.size()), 64'd0);
      q4.delete();
    end
  endtask

  initial begin
    int c0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_busy8", {63'd0, busy8}, 64'd0);
    check("rst_done8", {63'd0, done8}, 64'd0);
    check("rst_p8", {48'd0, p8}, 64'd0);
    check("rst_p4", {56'd0, p4}, 64'd0);

    // 255*255 with busy window and hold of p.
    @(negedge clk);
    a8 = 8'd255; b8 = 8'd255; s8 = 1'b0; start8 = 1'b1;
    q8.push_back('{64'hFE01, cyc + 1 + 8});
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start8 = 1'b0;
      check("busy_run", {63'd0, busy8}, 64'd1);
      check("done_run", {63'd0, done8}, 64'd0);
    end
    @(negedge clk);
    check("done_pulse", {63'd0, done8}, 64'd1);
    check("busy_at_done", {63'd0, busy8}, 64'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("p_hold", {48'd0, p8}, 64'hFE01);
      check("idle_flags", {62'd0, busy8, done8}, 64'd0);
    end

    // Signed corner cases.
    drive8(8'h80, 8'h80, 1'b1); drain8();
    drive8(8'hFD, 8'h05, 1'b1); drain8();
    drive8(8'h00, 8'h80, 1'b1); drain8();
    drive8(8'hFF, 8'h7F, 1'b1); drain8();

    // Start during RUN is ignored; operand changes have no effect.
    drive8(8'd7, 8'd6, 1'b0);
    @(negedge clk);
    a8 = 8'd9; b8 = 8'd9; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'h55; b8 = 8'hAA; s8 = 1'b1;
    drain8();
    repeat (12) @(negedge clk);

    // Back-to-back with start held high.
    @(negedge clk);
    c0 = cyc;
    a8 = 8'd3; b8 = 8'd4; s8 = 1'b0; start8 = 1'b1;
    q8.push_back('{64'd12, c0 + 9});
    @(negedge clk);
    a8 = 8'd10; b8 = 8'd10;
    q8.push_back('{64'd100, c0 + 18});
    while (cyc < c0 + 10) @(negedge clk);
    start8 = 1'b0;
    check("b2b_busy", {63'd0, busy8}, 64'd1);
    drain8();

    // Reset mid-multiply aborts without done.
    @(negedge clk);
    c0 = cyc;
    a8 = 8'd200; b8 = 8'd3; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    while (cyc < c0 + 4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", {63'd0, busy8}, 64'd0);
    check("abort_done", {63'd0, done8}, 64'd0);
    check("abort_p", {48'd0, p8}, 64'd0);
    repeat (14) @(negedge clk);
    drive8(8'd2, 8'd3, 1'b0); drain8();

    // Exhaustive 4-bit sweep in both modes.
    for (int s = 0; s < 2; s++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++) begin
          drive4(4'(x), 4'(y), 1'(s));
          drain4();
        end

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_array_mult.md
Name: seq_array_mult

Overview:
- Parametrised sequential shift-and-add multiplier, successor to the fixed 4x4 combinational array multiplier.
- Produces one partial-product row per clock, so area stays nearly flat as WIDTH grows.
- Adds a start/busy/done handshake and a selectable two's-complement signed mode.
- Sits in the lab datapath wherever a multiplier result is consumed a fixed number of cycles after the request.

Parameters:
- WIDTH, 8, operand width in bits (legal range 2..32); product is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  Synchronous active-low reset, sampled on the rising edge of clk.
- start  input  1  Request; sampled high in IDLE or DONE, it latches the operands and begins a multiply.
- signed_mode  input  1  Sampled with start: 1 = operands and product are two's complement, 0 = unsigned.
- a  input  WIDTH  Multiplicand, sampled with start.
- b  input  WIDTH  Multiplier, sampled with start.
- busy  output  1  High while a multiply is in progress (RUN state).
- done  output  1  One-cycle pulse; p is valid and final in this cycle.
- p  output  2*WIDTH  Product register; holds the last result until the next result is written.

Behaviour:
- Reset: when rst_n is low at a rising edge, state=IDLE, busy=0, done=0, p=0, and all internal registers (accumulator, operand copies, counter, sign flag) are cleared. Reset overrides everything, including a multiply in progress or a concurrent start; an aborted multiply never produces done.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 -> latch operands, count=0, go to RUN. start=0 -> stay in IDLE.
  - RUN: each edge processes one multiplier bit (LSB first). If the current multiplier bit is 1, add the magnitude of a, shifted left by count, into the 2*WIDTH accumulator; then count++. On the edge that processes bit WIDTH-1, write the final result to p and go to DONE.
  - DONE: done=1 for exactly this cycle. start=1 -> accept a new request exactly as in IDLE and go to RUN (back-to-back operation). start=0 -> go to IDLE.
- Latency: start is sampled at edge k. busy=1 from edge k to edge k+WIDTH. p is updated and done=1 from edge k+WIDTH to edge k+WIDTH+1. Latency is fixed regardless of operand values; there is no early exit on zero operands.
- Throughput: one result per WIDTH+1 cycles with continuous start.
- start while in RUN is ignored; changes to a, b or signed_mode during RUN have no effect.
- p changes only on the edge that enters DONE (and on reset). It is stable at all other times, including across IDLE.
- Signed mode:
  - At latch time, take magnitudes |a| and |b| as WIDTH-bit unsigned values. The most-negative value -2^(WIDTH-1) has magnitude 2^(WIDTH-1), which fits.
  - Record neg = a[MSB] XOR b[MSB].
  - Final p = neg ? (2's-complement negation of the accumulator, modulo 2^(2*WIDTH)) : accumulator.
  - Zero results are never negated into a nonzero value; a zero operand gives p=0.
- Unsigned mode: the operands are used directly and neg is forced to 0.
- Arithmetic: the accumulator is 2*WIDTH bits. No overflow is possible in either mode, since the full product always fits in 2*WIDTH bits.
- busy and done are never high in the same cycle. In IDLE, busy=0 and done=0.

Test Plan:
- WIDTH=8, unsigned, a=255, b=255, start 1 cycle -> busy high 8 cycles, then done pulse 1 cycle with p=16'hFE01; p holds 16'hFE01 through a further 10 idle cycles.
- WIDTH=8, signed, a=8'h80, b=8'h80 -> p=16'h4000. a=8'hFD(-3), b=8'h05 -> p=16'hFFF1. a=8'h00, b=8'h80 -> p=16'h0000. Each result arrives 8 cycles after start with done=1.
- WIDTH=8, start a=7, b=6; on cycle 3 of RUN, pulse start with a=9, b=9 and also change a, b -> the second start is ignored and the single result is p=42 at the expected cycle.
- WIDTH=8, start held high continuously with new operands presented at each accepting cycle -> results 3*4=12 then 10*10=100; done pulses 9 cycles apart, with no IDLE cycle in between.
- WIDTH=8, start a=200, b=3, then assert rst_n=0 on RUN cycle 4 for one edge -> busy=0, done=0, p=0 next cycle; no done pulse follows. A subsequent start a=2, b=3 yields p=6.
- WIDTH=4, exhaustive sweep of all 256 operand pairs in both modes -> p matches the reference product (unsigned a*b, or signed a*b sign-extended to 8 bits); done latency is always 4 cycles.
